// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, NOP encoding, register-select
// field positions and the fetch/decode queue entry type.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int REG_SEL_W = 5;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // Register-select fields inside an instruction word
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    // One buffered fetch result
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_entry_t;

    // First register-file read select of an instruction
    function automatic logic [REG_SEL_W-1:0] rs_of(input logic [XLEN-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    // Second register-file read select of an instruction
    function automatic logic [REG_SEL_W-1:0] rt_of(input logic [XLEN-1:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue. DEPTH-entry circular buffer with
// registered head; outputs depend only on stored state, so there is no
// combinational path from fetch inputs or dec_ready_i to any output.
// Flush (branch redirect) beats push and pop and empties the queue.
module if_id_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    input  logic [XLEN-1:0]            fetch_instr_i,
    input  logic [XLEN-1:0]            fetch_pc_i,
    output logic                       fetch_ready_o,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [XLEN-1:0]            dec_instr_o,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [REG_SEL_W-1:0]       rs_sel_o,
    output logic [REG_SEL_W-1:0]       rt_sel_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    if_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    if_entry_t          w_head;

    // Handshake qualification; flush suppresses both sides
    always_comb begin
        w_empty       = (r_count == '0);
        fetch_ready_o = (r_count < DEPTH_CNT);
        dec_valid_o   = !w_empty;
        w_push        = fetch_valid_i && fetch_ready_o && !flush_i;
        w_pop         = dec_valid_o && dec_ready_i && !flush_i;
    end

    // Storage write; only the pushed slot changes, flush leaves data in place
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= '{instr: fetch_instr_i, pc: fetch_pc_i};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy tracking; simultaneous push and pop cancel out
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Decode-side view of the head entry; NOP/zero whenever empty
    always_comb begin
        w_head      = r_mem[r_rd_ptr];
        dec_instr_o = NOP_INSTR;
        dec_pc_o    = '0;
        rs_sel_o    = '0;
        rt_sel_o    = '0;
        if (!w_empty) begin
            dec_instr_o = w_head.instr;
            dec_pc_o    = w_head.pc;
            rs_sel_o    = rs_of(w_head.instr);
            rt_sel_o    = rt_of(w_head.instr);
        end
        count_o = r_count;
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised and directed bench for if_id_queue. The stimulus side keeps a
// plain queue of expected entries; a monitor compares DUT outputs with it
// every cycle and retires entries as decode consumes them.
module tb_if_id_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            flush_i;
    logic            fetch_valid_i;
    logic [31:0]     fetch_instr_i;
    logic [31:0]     fetch_pc_i;
    logic            fetch_ready_o;
    logic            dec_valid_o;
    logic            dec_ready_i;
    logic [31:0]     dec_instr_o;
    logic [31:0]     dec_pc_o;
    logic [4:0]      rs_sel_o;
    logic [4:0]      rt_sel_o;
    logic [CW-1:0]   count_o;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_ready_o (fetch_ready_o),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_instr_o   (dec_instr_o),
        .dec_pc_o      (dec_pc_o),
        .rs_sel_o      (rs_sel_o),
        .rt_sel_o      (rt_sel_o),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t exp_q[$];

    int vectors = 0;
    int errors  = 0;
    bit mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model updates on the clock edge
    task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit fl);
        bit acc;
        @(negedge clk_i);
        fetch_valid_i = v;
        fetch_instr_i = ins;
        fetch_pc_i    = pc;
        dec_ready_i   = rdy;
        flush_i       = fl;
        #1;
        acc = v && !fl && (exp_q.size() < DEPTH);
        @(posedge clk_i);
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back('{instr: ins, pc: pc});
        #1;
    endtask

    // Monitor: outputs reflect the model head; retire on a decode handshake
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (mon_en && rst_n_i) begin
                chk("mon_count", 32'(count_o), 32'(exp_q.size()));
                chk("mon_valid", 32'(dec_valid_o), 32'(exp_q.size() != 0));
                chk("mon_ready", 32'(fetch_ready_o), 32'(exp_q.size() < DEPTH));
                if (exp_q.size() == 0) begin
                    chk("mon_nop", dec_instr_o, 32'h0);
                    chk("mon_pc0", dec_pc_o, 32'h0);
                end else begin
                    chk("mon_instr", dec_instr_o, exp_q[0].instr);
                    chk("mon_pc", dec_pc_o, exp_q[0].pc);
                    chk("mon_rs", 32'(rs_sel_o), (exp_q[0].instr / 32'h20_0000) % 32);
                    chk("mon_rt", 32'(rt_sel_o), (exp_q[0].instr / 32'h1_0000) % 32);
                    if (dec_ready_i && !flush_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n_i = 1'b0;
        flush_i = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_instr_i = '0;
        fetch_pc_i = '0;
        dec_ready_i = 1'b0;
        #3;
        chk("rst_valid", 32'(dec_valid_o), 32'h0);
        chk("rst_ready", 32'(fetch_ready_o), 32'h1);
        chk("rst_instr", dec_instr_o, 32'h0);
        chk("rst_count", 32'(count_o), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        mon_en  = 1'b1;

        // Single pass
        cyc(1, 32'h0123_4820, 32'h100, 1, 0);
        chk("sp_valid", 32'(dec_valid_o), 32'h1);
        chk("sp_rs", 32'(rs_sel_o), 32'd9);
        chk("sp_rt", 32'(rt_sel_o), 32'd3);
        chk("sp_pc", dec_pc_o, 32'h100);
        cyc(0, 0, 0, 1, 0);
        chk("sp_empty", 32'(count_o), 32'h0);

        // Fill while decode stalls
        cyc(1, 32'h1111_0000, 32'h200, 0, 0);
        cyc(1, 32'h2222_0000, 32'h204, 0, 0);
        chk("fill_count", 32'(count_o), 32'd2);
        chk("fill_ready", 32'(fetch_ready_o), 32'h0);
        cyc(1, 32'h3333_0000, 32'h208, 0, 0);
        chk("fill_count2", 32'(count_o), 32'd2);
        chk("fill_head", dec_pc_o, 32'h200);
        repeat (5) cyc(0, 0, 0, 0, 0);
        chk("stall_head", dec_pc_o, 32'h200);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Streaming push/pop at count 1 across pointer wrap
        cyc(1, 32'hA000_0000, 32'h300, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 32'hA000_0000 + 32'(k), 32'h300 + 32'(4 * k), 1, 0);
            chk("stream_count", 32'(count_o), 32'd1);
            chk("stream_pc", dec_pc_o, 32'h300 + 32'(4 * k));
        end
        cyc(0, 0, 0, 1, 0);

        // Flush at count 2 with a fetch in the same cycle
        cyc(1, 32'h0044_0001, 32'h500, 0, 0);
        cyc(1, 32'h0044_0002, 32'h504, 0, 0);
        cyc(1, 32'hDEAD_BEEF, 32'h5000, 1, 1);
        chk("flush_count", 32'(count_o), 32'h0);
        chk("flush_instr", dec_instr_o, 32'h0);
        cyc(1, 32'h0066_0000, 32'h600, 0, 0);
        chk("flush_next", dec_pc_o, 32'h600);
        cyc(0, 0, 0, 1, 0);

        // Asynchronous reset mid-operation at count 2
        cyc(1, 32'h0077_0001, 32'h700, 0, 0);
        cyc(1, 32'h0077_0002, 32'h704, 0, 0);
        @(negedge clk_i);
        fetch_valid_i = 1'b0;
        #3;
        rst_n_i = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_count", 32'(count_o), 32'h0);
        chk("arst_valid", 32'(dec_valid_o), 32'h0);
        chk("arst_instr", dec_instr_o, 32'h0);
        chk("arst_ready", 32'(fetch_ready_o), 32'h1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cyc(1, 32'h0088_0000, 32'h400, 0, 0);
        chk("post_rst_head", dec_pc_o, 32'h400);
        cyc(0, 0, 0, 1, 0);

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            cyc(bit'($urandom_range(0, 3) != 0), $urandom, $urandom,
                bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 31) == 0));
        end
        repeat (4) cyc(0, 0, 0, 1, 0);
        chk("final_count", 32'(count_o), 32'h0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter: DEPTH, 2, number of instruction entries buffered between fetch and decode; power of two, at least 2.
REQ-002 clk_i  input  1  clock; all state changes on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 flush_i  input  1  discard all buffered entries (branch/jump redirect).
REQ-005 fetch_valid_i  input  1  fetch presents an instruction this cycle.
REQ-006 fetch_instr_i  input  32  fetched instruction word.
REQ-007 fetch_pc_i  input  32  PC of fetched instruction.
REQ-008 fetch_ready_o  output  1  queue accepts an entry this cycle.
REQ-009 dec_valid_o  output  1  head entry valid for decode.
REQ-010 dec_ready_i  input  1  decode consumes the head entry this cycle (low = hazard stall).
REQ-011 dec_instr_o  output  32  head instruction word; NOP (32'h0000_0000) when empty.
REQ-012 dec_pc_o  output  32  head PC; 0 when empty.
REQ-013 rs_sel_o  output  5  instr[25:21] of head; register-file read port 1 select; 0 when empty.
REQ-014 rt_sel_o  output  5  instr[20:16] of head; register-file read port 2 select; 0 when empty.
REQ-015 count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Push occurs when fetch_valid_i && fetch_ready_o && !flush_i; entry written at write pointer, pointer increments modulo DEPTH.
REQ-017 Pop occurs when dec_valid_o && dec_ready_i && !flush_i; read pointer increments modulo DEPTH.
REQ-018 fetch_ready_o = (count < DEPTH); no combinational path from dec_ready_i to fetch_ready_o.
REQ-019 dec_valid_o = (count != 0); all dec_* and *_sel_o outputs driven combinationally from the registered head entry only.
REQ-020 Latency: an entry pushed in cycle N appears on dec_* outputs in cycle N+1; no fetch-to-decode bypass.
REQ-021 Count: push only +1; pop only -1; push and pop in same cycle leaves count unchanged (legal whenever 0 < count < DEPTH).
REQ-022 Full (count = DEPTH): fetch_ready_o low; a pop in that cycle does not permit a same-cycle push.
REQ-023 Empty (count = 0): dec_valid_o low, dec_ready_i ignored, NOP/zero outputs per REQ-011..014.
REQ-024 Pointer wrap-around from DEPTH-1 to 0 preserves FIFO order with no lost or duplicated entry.
REQ-025 Flush has priority over push and pop: next cycle count = 0, both pointers = 0; fetch data presented in the flush cycle is dropped.
REQ-026 Flush while empty is a no-op apart from pointer reset.
REQ-027 Storage content need not be cleared on flush; only valid tracking is reset.
REQ-028 dec_ready_i held low holds head entry and all dec_* outputs stable indefinitely.

Reset
REQ-029 Asynchronous assertion of rst_n_i clears count, both pointers and all storage to 0 immediately; fetch_ready_o = 1, dec_valid_o = 0, dec_instr_o = NOP.
REQ-030 Reset asserted mid-operation discards all entries; first push after deassertion is accepted on the first rising edge with rst_n_i high.

Structure
REQ-031 Shared package cpu_pkg holds XLEN = 32, REG_SEL_W = 5, NOP_INSTR = 32'h0, RS/RT field bit positions and an instruction entry struct {instr, pc}.
REQ-032 Single module; no sub-module; storage is a DEPTH-entry array of the entry struct.

Verification
REQ-033 Single pass: push instr 32'h0123_4820 pc 32'h100, dec_ready_i = 1 -> next cycle dec_valid_o = 1, rs_sel_o = 9, rt_sel_o = 3, dec_pc_o = 32'h100, then empty.
REQ-034 Fill and stall: dec_ready_i = 0, push pc 32'h200, 32'h204, 32'h208 back-to-back -> first two accepted, fetch_ready_o = 0 on third, count_o = 2, head pc 32'h200 held.
REQ-035 Simultaneous push/pop at count 1 for 10 cycles with pc 32'h300+4k -> count_o stays 1, pops emerge in order 32'h300, 32'h304, ... across pointer wrap.
REQ-036 Flush with count 2 and fetch_valid_i = 1 same cycle -> next cycle count_o = 0, dec_instr_o = 32'h0, flush-cycle instruction never appears.
REQ-037 Reset mid-operation at count 2 -> outputs immediately zero/NOP, fetch_ready_o = 1; post-reset push pc 32'h400 is first entry popped.
REQ-038 Random valid/ready/flush traffic against a scoreboard model for 10k cycles -> no ordering, loss or duplication error.
